axi_lite_mgr: RTL and testbench

Single-outstanding AXI4-Lite manager that turns testbench transfer requests into AXI channel handshakes and reports what comes back. It sits directly downstream of the testbench control interface's manager modport, where it consumes `mgr_tx_AW`, `mgr_tx_W`, `mgr_tx_AR` and `tx_en`. It drives `mgr_rx_R`, `mgr_bresp`, `mgr_rresp` and `mgr_new_data` back, and its AXI side connects to the interconnect or subordinate.

---
 rtl/axi_lite_mgr_if.sv | 38 +++
 rtl/axi_lite_mgr.sv | 216 +++++++++++++++++++++
 tb/tb_axi_lite_mgr.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mgr_if.sv
// AXI4-Lite channel bundle between the manager and an interconnect or subordinate.
// The master modport is the manager's view; the slave modport is the subordinate's view.
interface axi_lite_mgr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_mgr.sv
// Single-outstanding AXI4-Lite manager. Independent write and read FSMs turn
// request strobes (tx_en) into AXI handshakes and capture the responses.
// Optional feature macro: AXI_MGR_TIMEOUT_EN builds per-FSM response-wait
// counters driving a sticky mgr_timeout flag; without it mgr_timeout is 0.
module axi_lite_mgr #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] mgr_tx_AW,
  input  logic [ADDR_W-1:0] mgr_tx_AR,
  input  logic [DATA_W-1:0] mgr_tx_W,
  input  logic [4:0]        tx_en,
  output logic [DATA_W-1:0] mgr_rx_R,
  output logic [1:0]        mgr_bresp,
  output logic [1:0]        mgr_rresp,
  output logic [4:0]        mgr_new_data,
  output logic              mgr_timeout,
  axi_lite_mgr_if.master    axi
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  // Write channel state
  w_state_t              r_wstate, w_wstate_next;
  logic                  r_awvalid, w_awvalid_next;
  logic                  r_wvalid, w_wvalid_next;
  logic [ADDR_W-1:0]     r_awaddr, w_awaddr_next;
  logic [DATA_W-1:0]     r_wdata, w_wdata_next;
  logic [DATA_W/8-1:0]   r_wstrb, w_wstrb_next;
  logic [1:0]            r_bresp, w_bresp_next;

  // Read channel state
  r_state_t              r_rstate, w_rstate_next;
  logic                  r_arvalid, w_arvalid_next;
  logic [ADDR_W-1:0]     r_araddr, w_araddr_next;
  logic [DATA_W-1:0]     r_rdata, w_rdata_next;
  logic [1:0]            r_rresp, w_rresp_next;

  logic [4:0]            r_new_data;

  logic w_bready, w_rready;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  // READY on the response channels is gated by the caller's enable only while waiting
  assign w_bready = (r_wstate == W_RESP) && tx_en[2];
  assign w_rready = (r_rstate == R_DATA) && tx_en[0];

  assign w_aw_hs = r_awvalid & axi.AWREADY;
  assign w_w_hs  = r_wvalid  & axi.WREADY;
  assign w_b_hs  = w_bready  & axi.BVALID;
  assign w_ar_hs = r_arvalid & axi.ARREADY;
  assign w_r_hs  = w_rready  & axi.RVALID;

  // Write FSM next-state: issue AW+W together, retire each independently, then wait for B
  always_comb begin
    w_wstate_next  = r_wstate;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_awaddr_next  = r_awaddr;
    w_wdata_next   = r_wdata;
    w_wstrb_next   = r_wstrb;
    w_bresp_next   = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        if (tx_en[4] && tx_en[3]) begin
          w_awaddr_next  = mgr_tx_AW;
          w_wdata_next   = mgr_tx_W;
          w_wstrb_next   = '1;
          w_awvalid_next = 1'b1;
          w_wvalid_next  = 1'b1;
          w_wstate_next  = W_ADDR;
        end
      end
      W_ADDR: begin
        if (w_aw_hs) w_awvalid_next = 1'b0;
        if (w_w_hs)  w_wvalid_next  = 1'b0;
        if (!w_awvalid_next && !w_wvalid_next) w_wstate_next = W_RESP;
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_bresp_next  = axi.BRESP;
          w_wstate_next = W_IDLE;
        end
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // Write FSM register; reset drops VALIDs and abandons any pending handshake
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= 2'b00;
    end else begin
      r_wstate  <= w_wstate_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      r_awaddr  <= w_awaddr_next;
      r_wdata   <= w_wdata_next;
      r_wstrb   <= w_wstrb_next;
      r_bresp   <= w_bresp_next;
    end
  end

  // Read FSM next-state: issue AR, then wait for R while the caller allows RREADY
  always_comb begin
    w_rstate_next  = r_rstate;
    w_arvalid_next = r_arvalid;
    w_araddr_next  = r_araddr;
    w_rdata_next   = r_rdata;
    w_rresp_next   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        if (tx_en[1]) begin
          w_araddr_next  = mgr_tx_AR;
          w_arvalid_next = 1'b1;
          w_rstate_next  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (w_ar_hs) begin
          w_arvalid_next = 1'b0;
          w_rstate_next  = R_DATA;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rdata_next  = axi.RDATA;
          w_rresp_next  = axi.RRESP;
          w_rstate_next = R_IDLE;
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // Read FSM register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_rstate  <= w_rstate_next;
      r_arvalid <= w_arvalid_next;
      r_araddr  <= w_araddr_next;
      r_rdata   <= w_rdata_next;
      r_rresp   <= w_rresp_next;
    end
  end

  // One-cycle completion pulses, one bit per channel in tx_en order
  always_ff @(posedge ACLK) begin
    if (ARESET) r_new_data <= 5'b00000;
    else        r_new_data <= {w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs};
  end

`ifdef AXI_MGR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wcnt, r_rcnt;
  logic             r_timeout;

  // Counters rest at zero outside the response-wait states, so entry starts from zero;
  // the flag sets on the cycle either counter reaches TIMEOUT and stays until reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_wstate != W_RESP)                r_wcnt <= '0;
      else if (r_wcnt != CNT_W'(TIMEOUT))    r_wcnt <= r_wcnt + 1'b1;
      if (r_rstate != R_DATA)                r_rcnt <= '0;
      else if (r_rcnt != CNT_W'(TIMEOUT))    r_rcnt <= r_rcnt + 1'b1;
      if ((r_wstate == W_RESP && r_wcnt == CNT_W'(TIMEOUT - 1)) ||
          (r_rstate == R_DATA && r_rcnt == CNT_W'(TIMEOUT - 1)))
        r_timeout <= 1'b1;
    end
  end

  assign mgr_timeout = r_timeout;
`else
  // No counters built; the comparison is always false and keeps TIMEOUT referenced
  assign mgr_timeout = (TIMEOUT < 0);
`endif

  assign axi.AWADDR  = r_awaddr;
  assign axi.AWPROT  = 3'b000;
  assign axi.AWVALID = r_awvalid;
  assign axi.WDATA   = r_wdata;
  assign axi.WSTRB   = r_wstrb;
  assign axi.WVALID  = r_wvalid;
  assign axi.BREADY  = w_bready;
  assign axi.ARADDR  = r_araddr;
  assign axi.ARPROT  = 3'b000;
  assign axi.ARVALID = r_arvalid;
  assign axi.RREADY  = w_rready;

  assign mgr_rx_R     = r_rdata;
  assign mgr_bresp    = r_bresp;
  assign mgr_rresp    = r_rresp;
  assign mgr_new_data = r_new_data;

endmodule

// File: tb/tb_axi_lite_mgr.sv
// Bench for axi_lite_mgr: table of zero-wait transactions, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_axi_lite_mgr;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] tx_aw = '0, tx_ar = '0;
  logic [DW-1:0] tx_w = '0;
  logic [4:0]    tx_en = '0;
  logic [DW-1:0] rx_r;
  logic [1:0]    bresp_o, rresp_o;
  logic [4:0]    nd;
  logic          tmo;

  axi_lite_mgr_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_mgr #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .mgr_tx_AW(tx_aw), .mgr_tx_AR(tx_ar), .mgr_tx_W(tx_w), .tx_en(tx_en),
    .mgr_rx_R(rx_r), .mgr_bresp(bresp_o), .mgr_rresp(rresp_o),
    .mgr_new_data(nd), .mgr_timeout(tmo), .axi(bus)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;

  // Reference model: outstanding-transaction bookkeeping
  logic          m_wbusy, m_awp, m_wp, m_bph, m_rbusy, m_arp, m_rph, m_to;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [7:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  int            m_wcyc, m_rcyc;

  // Values seen just before an edge
  logic          p_aw, p_w, p_b, p_ar, p_r, p_rst;
  logic [1:0]    p_bresp, p_rresp;
  logic [DW-1:0] p_rdata;

  // Subordinate model controls
  logic          manual;
  logic          s_fixed;
  int            rdy_pct, rsp_pct;
  logic          s_awgot, s_wgot;
  int            s_bowed, s_rowed;
  logic [1:0]    s_bresp_v, s_rresp_v;
  logic [DW-1:0] s_rdata_v;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic model_reset();
    m_wbusy = 0; m_awp = 0; m_wp = 0; m_bph = 0;
    m_rbusy = 0; m_arp = 0; m_rph = 0; m_to = 0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_rdata = '0;
    m_wstrb = '0; m_bresp = '0; m_rresp = '0; m_wcyc = 0; m_rcyc = 0;
  endtask

  task automatic slave_quiet();
    bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
    bus.BVALID = 0; bus.BRESP = '0; bus.RVALID = 0; bus.RRESP = '0; bus.RDATA = '0;
    s_awgot = 0; s_wgot = 0; s_bowed = 0; s_rowed = 0;
  endtask

  // Transaction-level update using the request inputs (still held) and sampled handshakes
  task automatic model_update();
    if (p_rst) begin
      model_reset();
      return;
    end
    if (!m_wbusy) begin
      if (tx_en[4] && tx_en[3]) begin
        m_wbusy = 1; m_awp = 1; m_wp = 1; m_bph = 0;
        m_awaddr = tx_aw; m_wdata = tx_w; m_wstrb = 8'hFF;
      end
    end else if (m_bph) begin
      m_wcyc++;
      if (m_wcyc == TO) m_to = 1;
      if (p_b) begin
        m_wbusy = 0; m_bph = 0; m_bresp = p_bresp;
        $display("write addr=%h data=%h bresp=%0d", m_awaddr, m_wdata, m_bresp);
      end
    end else begin
      if (p_aw) m_awp = 0;
      if (p_w)  m_wp = 0;
      if (!m_awp && !m_wp) begin m_bph = 1; m_wcyc = 0; end
    end
    if (!m_rbusy) begin
      if (tx_en[1]) begin m_rbusy = 1; m_arp = 1; m_araddr = tx_ar; end
    end else if (m_rph) begin
      m_rcyc++;
      if (m_rcyc == TO) m_to = 1;
      if (p_r) begin
        m_rbusy = 0; m_rph = 0; m_rdata = p_rdata; m_rresp = p_rresp;
        $display("read  addr=%h data=%h rresp=%0d", m_araddr, m_rdata, m_rresp);
      end
    end else if (p_ar) begin
      m_arp = 0; m_rph = 1; m_rcyc = 0;
    end
  endtask

  // Reactive subordinate with configurable READY and response probabilities
  task automatic slave_update();
    if (p_rst) begin slave_quiet(); return; end
    if (p_aw) s_awgot = 1;
    if (p_w)  s_wgot = 1;
    if (s_awgot && s_wgot) begin s_awgot = 0; s_wgot = 0; s_bowed++; end
    if (p_b) begin bus.BVALID = 0; s_bowed--; end
    if (!bus.BVALID && s_bowed > 0 && roll(rsp_pct)) begin
      bus.BVALID = 1;
      bus.BRESP = s_fixed ? s_bresp_v : 2'($urandom);
    end
    if (p_ar) s_rowed++;
    if (p_r) begin bus.RVALID = 0; s_rowed--; end
    if (!bus.RVALID && s_rowed > 0 && roll(rsp_pct)) begin
      bus.RVALID = 1;
      bus.RDATA = s_fixed ? s_rdata_v : {$urandom, $urandom};
      bus.RRESP = s_fixed ? s_rresp_v : 2'($urandom);
    end
    bus.AWREADY = roll(rdy_pct);
    bus.WREADY  = roll(rdy_pct);
    bus.ARREADY = roll(rdy_pct);
  endtask

  // One clock: check bus-side outputs mid-cycle, then the registered outputs after the edge
  task automatic cycle();
    logic exp_to;
    @(negedge ACLK);
    p_aw = bus.AWVALID & bus.AWREADY;
    p_w  = bus.WVALID & bus.WREADY;
    p_b  = bus.BVALID & bus.BREADY;
    p_ar = bus.ARVALID & bus.ARREADY;
    p_r  = bus.RVALID & bus.RREADY;
    p_bresp = bus.BRESP; p_rresp = bus.RRESP; p_rdata = bus.RDATA;
    p_rst = ARESET;
    chk("awvalid", 64'(bus.AWVALID), 64'(m_awp));
    chk("wvalid",  64'(bus.WVALID),  64'(m_wp));
    chk("arvalid", 64'(bus.ARVALID), 64'(m_arp));
    chk("bready",  64'(bus.BREADY),  64'(m_bph & tx_en[2]));
    chk("rready",  64'(bus.RREADY),  64'(m_rph & tx_en[0]));
    chk("awaddr",  64'(bus.AWADDR),  64'(m_awaddr));
    chk("araddr",  64'(bus.ARADDR),  64'(m_araddr));
    chk("wdata",   bus.WDATA,        m_wdata);
    chk("wstrb",   64'(bus.WSTRB),   64'(m_wstrb));
    @(posedge ACLK);
    #1;
    model_update();
    chk("new_data", 64'(nd), p_rst ? 64'h0 : 64'({p_aw, p_w, p_b, p_ar, p_r}));
    chk("bresp", 64'(bresp_o), 64'(m_bresp));
    chk("rresp", 64'(rresp_o), 64'(m_rresp));
    chk("rx_r",  rx_r, m_rdata);
`ifdef AXI_MGR_TIMEOUT_EN
    exp_to = m_to;
`else
    exp_to = 1'b0;
`endif
    chk("timeout", 64'(tmo), 64'(exp_to));
    if (!manual) slave_update();
  endtask

  task automatic do_reset();
    slave_quiet();
    ARESET = 1; tx_en = '0;
    cycle(); cycle();
    ARESET = 0;
  endtask

  typedef struct {
    logic [4:0]  en;
    logic [31:0] aw;
    logic [63:0] w;
    logic [31:0] ar;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    logic [2:0]  exp_v;
    logic [4:0]  exp_nd1, exp_nd2;
    logic [1:0]  exp_bresp, exp_rresp;
    logic [63:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] hold;
    bit to_en;
`ifdef AXI_MGR_TIMEOUT_EN
    to_en = 1;
`else
    to_en = 0;
`endif
    vecs[0] = '{5'b11100, 32'h10,  64'hDEADBEEF_CAFEF00D, 32'h0,   2'b00, 2'b00, 64'h0,
                3'b110, 5'b11000, 5'b00100, 2'b00, 2'b00, 64'h0};
    vecs[1] = '{5'b00011, 32'h0,   64'h0,                 32'h20,  2'b00, 2'b10, 64'h1234,
                3'b001, 5'b00010, 5'b00001, 2'b00, 2'b10, 64'h1234};
    vecs[2] = '{5'b11111, 32'h100, 64'h01234567_89ABCDEF, 32'h200, 2'b01, 2'b11, 64'hFEDCBA98_76543210,
                3'b111, 5'b11010, 5'b00101, 2'b01, 2'b11, 64'hFEDCBA98_76543210};
    vecs[3] = '{5'b10100, 32'h44,  64'h1,                 32'h0,   2'b10, 2'b00, 64'h0,
                3'b000, 5'b00000, 5'b00000, 2'b01, 2'b11, 64'hFEDCBA98_76543210};
    vecs[4] = '{5'b01100, 32'h48,  64'h2,                 32'h0,   2'b10, 2'b00, 64'h0,
                3'b000, 5'b00000, 5'b00000, 2'b01, 2'b11, 64'hFEDCBA98_76543210};
    vecs[5] = '{5'b11101, 32'h30,  64'h55555555_AAAAAAAA, 32'h0,   2'b11, 2'b00, 64'h0,
                3'b110, 5'b11000, 5'b00100, 2'b11, 2'b11, 64'hFEDCBA98_76543210};

    model_reset();
    manual = 0; s_fixed = 1; rdy_pct = 100; rsp_pct = 100;
    s_bresp_v = '0; s_rresp_v = '0; s_rdata_v = '0;
    do_reset();

    // Reset state
    chk("rst_awvalid", 64'(bus.AWVALID), 64'h0);
    chk("rst_arvalid", 64'(bus.ARVALID), 64'h0);
    chk("rst_wstrb",   64'(bus.WSTRB),   64'h0);
    chk("rst_new",     64'(nd),          64'h0);
    chk("rst_rx",      rx_r,             64'h0);
    chk("rst_timeout", 64'(tmo),         64'h0);

    // Zero-wait transaction table
    for (int i = 0; i < 6; i++) begin
      s_bresp_v = vecs[i].bresp; s_rresp_v = vecs[i].rresp; s_rdata_v = vecs[i].rdata;
      tx_aw = vecs[i].aw; tx_w = vecs[i].w; tx_ar = vecs[i].ar; tx_en = vecs[i].en;
      cycle();
      tx_en = vecs[i].en & 5'b00101;
      chk("vec_valid", 64'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v[2]) chk("vec_wstrb", 64'(bus.WSTRB), 64'hFF);
      cycle();
      chk("vec_nd1", 64'(nd), 64'(vecs[i].exp_nd1));
      cycle();
      chk("vec_nd2", 64'(nd), 64'(vecs[i].exp_nd2));
      cycle();
      chk("vec_nd3", 64'(nd), 64'h0);
      chk("vec_bresp", 64'(bresp_o), 64'(vecs[i].exp_bresp));
      chk("vec_rresp", 64'(rresp_o), 64'(vecs[i].exp_rresp));
      chk("vec_rx", rx_r, vecs[i].exp_rx);
      tx_en = '0;
      cycle();
      $display("vec %0d en=%b bresp=%0d rresp=%0d rx=%h", i, vecs[i].en, bresp_o, rresp_o, rx_r);
    end

    // Staggered AW/W handshakes
    manual = 1; slave_quiet();
    tx_aw = 32'h40; tx_w = 64'h11112222_33334444; tx_en = 5'b11100;
    cycle();
    tx_en = 5'b00100;
    chk("stg_awv", 64'(bus.AWVALID), 64'h1);
    chk("stg_wv",  64'(bus.WVALID),  64'h1);
    bus.AWREADY = 1;
    cycle();
    bus.AWREADY = 0;
    chk("stg_awdrop", 64'(bus.AWVALID), 64'h0);
    chk("stg_nd_aw",  64'(nd), 64'b10000);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stg_whold", 64'(bus.WVALID), 64'h1);
      chk("stg_wdata", bus.WDATA, 64'h11112222_33334444);
      chk("stg_nobready", 64'(bus.BREADY), 64'h0);
    end
    bus.WREADY = 1;
    cycle();
    bus.WREADY = 0;
    chk("stg_wdrop", 64'(bus.WVALID), 64'h0);
    chk("stg_nd_w",  64'(nd), 64'b01000);
    chk("stg_bready", 64'(bus.BREADY), 64'h1);
    bus.BVALID = 1; bus.BRESP = 2'b01;
    cycle();
    bus.BVALID = 0;
    chk("stg_nd_b",  64'(nd), 64'b00100);
    chk("stg_bresp", 64'(bresp_o), 64'h1);
    tx_en = '0;
    cycle();
    $display("staggered write bresp=%0d", bresp_o);

    // Read with RREADY gated off
    tx_ar = 32'h20; tx_en = 5'b00010; bus.ARREADY = 1;
    cycle();
    tx_en = '0;
    chk("rg_arv",   64'(bus.ARVALID), 64'h1);
    chk("rg_araddr", 64'(bus.ARADDR), 64'h20);
    cycle();
    chk("rg_nd_ar", 64'(nd), 64'b00010);
    bus.ARREADY = 0; bus.RVALID = 1; bus.RDATA = 64'h1234; bus.RRESP = 2'b10;
    hold = rx_r;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rg_rready0", 64'(bus.RREADY), 64'h0);
      chk("rg_rxhold", rx_r, hold);
    end
    tx_en = 5'b00001;
    #1;
    chk("rg_rready1", 64'(bus.RREADY), 64'h1);
    cycle();
    bus.RVALID = 0; tx_en = '0;
    chk("rg_rx",    rx_r, 64'h1234);
    chk("rg_rresp", 64'(rresp_o), 64'h2);
    chk("rg_nd_r",  64'(nd), 64'b00001);
    $display("gated read rx=%h rresp=%0d", rx_r, rresp_o);

    // Reset while AWVALID is high and AWREADY is low
    tx_aw = 32'h80; tx_w = 64'h9; tx_ar = 32'h90; tx_en = 5'b11010;
    cycle();
    tx_en = '0;
    chk("mr_awv", 64'(bus.AWVALID), 64'h1);
    chk("mr_arv", 64'(bus.ARVALID), 64'h1);
    ARESET = 1;
    cycle();
    ARESET = 0;
    chk("mr_awv0", 64'(bus.AWVALID), 64'h0);
    chk("mr_wv0",  64'(bus.WVALID),  64'h0);
    chk("mr_arv0", 64'(bus.ARVALID), 64'h0);
    chk("mr_awaddr", 64'(bus.AWADDR), 64'h0);
    chk("mr_rx",   rx_r, 64'h0);
    chk("mr_rresp", 64'(rresp_o), 64'h0);
    chk("mr_bresp", 64'(bresp_o), 64'h0);
    cycle();
    $display("reset mid-operation done");

    // Response timeout: BVALID withheld for 20 cycles
    bus.AWREADY = 1; bus.WREADY = 1;
    tx_aw = 32'hA0; tx_w = 64'hBEEF; tx_en = 5'b11100;
    cycle();
    tx_en = 5'b00100;
    cycle();
    bus.AWREADY = 0; bus.WREADY = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      chk("to_flag", 64'(tmo), 64'(to_en && i >= TO));
    end
    bus.BVALID = 1; bus.BRESP = 2'b00;
    cycle();
    bus.BVALID = 0; tx_en = '0;
    chk("to_nd_b",  64'(nd), 64'b00100);
    cycle();
    chk("to_sticky", 64'(tmo), 64'(to_en));
    $display("timeout sequence flag=%0d", tmo);

    // Randomized traffic against the model
    manual = 0; s_fixed = 0; rdy_pct = 60; rsp_pct = 50;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tx_en = 5'($urandom);
      tx_aw = $urandom; tx_ar = $urandom; tx_w = {$urandom, $urandom};
      cycle();
    end
    tx_en = 5'b00101; rdy_pct = 100; rsp_pct = 100;
    for (int i = 0; i < 50 && (m_wbusy || m_rbusy); i++) cycle();
    total++;
    if (m_wbusy || m_rbusy) begin
      bad++;
      $display("FAIL drain: got busy w=%0d r=%0d want idle", m_wbusy, m_rbusy);
    end
    tx_en = '0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
